// File: rtl/seq_addsub_16bit_if.sv
// seq_addsub_16bit_if: start/done handshake and operand/result bus of the serial adder
interface seq_addsub_16bit_if #(parameter int WIDTH = 16);
  logic start;
  logic sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic c0;
  logic [WIDTH-1:0] s;
  logic c;
  logic v;
  logic busy;
  logic done;
  modport master (output start, sub, a, b, c0, input s, c, v, busy, done);
  modport slave (input start, sub, a, b, c0, output s, c, v, busy, done);
endinterface

// File: rtl/seq_addsub_16bit.sv
// seq_addsub_16bit: bit-serial adder/subtractor, one bit per clock through a registered full adder
module seq_addsub_16bit #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  seq_addsub_16bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb, rs;
  logic [CW-1:0] cnt;
  logic cy, sum, cout;
  // full adder on the current LSBs and the carry register
  always_comb begin
    sum = ra[0] ^ rb[0] ^ cy;
    cout = (ra[0] & rb[0]) | (cy & (ra[0] ^ rb[0]));
  end
  // operand latch, serial datapath and result/handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      cy <= 1'b0;
      cnt <= '0;
      bus.s <= '0;
      bus.c <= 1'b0;
      bus.v <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          ra <= bus.a;
          rb <= bus.sub ? ~bus.b : bus.b;
          cy <= bus.c0 ^ bus.sub;
          rs <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= RUN;
        end
      end else begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        rs <= {sum, rs[WIDTH-1:1]};
        cy <= cout;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          bus.s <= {sum, rs[WIDTH-1:1]};
          bus.c <= cout;
          bus.v <= cout ^ cy;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_addsub_16bit.sv
// tb_seq_addsub_16bit: table vectors, random ops against an arithmetic model, handshake corner cases
module tb_seq_addsub_16bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  seq_addsub_16bit_if #(.WIDTH(16)) bus ();
  seq_addsub_16bit #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic c0;
    logic sub;
    logic [15:0] s;
    logic c;
    logic v;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic c0, input logic sub);
    logic [15:0] bb;
    logic [16:0] full;
    logic vv;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 17'(sub ? !c0 : c0);
    vv = (a[15] == bb[15]) && (full[15] != a[15]);
    return {full[16], vv, full[15:0]};
  endfunction

  task automatic op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc0, input logic tsub,
                    output logic [17:0] res, output int lat, output int bcnt);
    @(negedge clk);
    bus.a = ta; bus.b = tb2; bus.c0 = tc0; bus.sub = tsub; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.c0 = 1'($urandom); bus.sub = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    res = {bus.c, bus.v, bus.s};
    chk("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [17:0] res, exp;
    int lat, bcnt, nd, last, gap;
    vecs[0] = '{16'h02EB, 16'h5555, 1'b0, 1'b0, 16'h5840, 1'b0, 1'b0};
    vecs[1] = '{16'h5555, 16'h02EB, 1'b0, 1'b1, 16'h526A, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c0 = 1'b0; bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {26'd0, bus.s, bus.c, bus.v, bus.busy, bus.done}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, res, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 16);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 16);
      chk($sformatf("vec%0d_result", i), {14'd0, res}, {14'd0, vecs[i].c, vecs[i].v, vecs[i].s});
    end

    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      logic rc, rs;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      exp = model(ra, rb, rc, rs);
      op(ra, rb, rc, rs, res, lat, bcnt);
      chk($sformatf("rand%0d_latency", i), lat, 16);
      chk($sformatf("rand%0d_result", i), {14'd0, res}, {14'd0, exp});
    end

    @(negedge clk);
    bus.a = 16'd1; bus.b = 16'd1; bus.c0 = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 16'hAAAA; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    res = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin nd++; res = {bus.c, bus.v, bus.s}; end
      @(negedge clk);
    end
    chk("busy_protect_done_count", nd, 1);
    chk("busy_protect_result", {14'd0, res}, {14'd0, 2'b00, 16'd2});
    chk("busy_protect_idle", {31'd0, bus.busy}, 32'd0);

    @(negedge clk);
    bus.a = 16'd3; bus.b = 16'd4; bus.c0 = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    nd = 0; last = 0; gap = 0;
    for (int k = 0; k < 80 && nd < 3; k++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        chk($sformatf("b2b%0d_result", nd), {14'd0, bus.c, bus.v, bus.s}, {14'd0, 2'b00, 16'd7});
        if (nd > 1) chk($sformatf("b2b%0d_spacing", nd), k - last, 17);
        last = k;
        if (nd < 3) begin
          @(negedge clk);
          k++;
          chk($sformatf("b2b%0d_busy_rise", nd), {30'd0, bus.busy, bus.done}, 32'd2);
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", nd, 3);
    repeat (20) @(negedge clk);

    bus.a = 16'h1234; bus.b = 16'h1111; bus.c0 = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outputs", {26'd0, bus.s, bus.c, bus.v, bus.busy, bus.done}, 32'd0);
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    chk("midreset_no_done", nd, 0);
    op(16'h1234, 16'h1111, 1'b0, 1'b0, res, lat, bcnt);
    chk("after_reset_latency", lat, 16);
    chk("after_reset_result", {14'd0, res}, {14'd0, 2'b00, 16'h2345});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
